// File: rtl/nasti_lite_arb_pkg.sv
// ============================================================================
//  Module      : nasti_lite_arb_pkg
//  Description : Shared types and round-robin pick function for the
//                NASTI-Lite arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nasti_lite_arb_pkg;

    // The pick function works on a fixed-width request vector; N_MASTER <= 32.
    localparam int MAX_MASTER = 32;
    localparam int MAX_IDX_W  = 5;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_REQ  = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rstate_t;

    // First requester at or after ptr. Unused upper request bits are zero,
    // so wrapping modulo 32 gives the same answer as wrapping modulo N.
    function automatic logic [MAX_IDX_W-1:0] rr_pick(
        input logic [MAX_MASTER-1:0] req,
        input logic [MAX_IDX_W-1:0]  ptr
    );
        logic [MAX_IDX_W-1:0] idx;
        logic [MAX_IDX_W-1:0] pick;
        logic                 found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_MASTER; k++) begin
            idx = ptr + MAX_IDX_W'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nasti_lite_rr_arb.sv
// ============================================================================
//  Module      : nasti_lite_rr_arb
//  Description : Round-robin grant holder with IDLE/REQ/RESP sequencing for
//                one NASTI-Lite path (one or more request channels).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nasti_lite_rr_arb
    import nasti_lite_arb_pkg::*;
#(
    parameter int N_MASTER = 2,
    parameter int N_CHAN   = 1,
    parameter int IDX_W    = $clog2(N_MASTER)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_MASTER-1:0] req,
    input  logic [N_CHAN-1:0]   chan_hs,
    input  logic                resp_hs,
    output logic [1:0]          state,
    output logic [IDX_W-1:0]    gnt,
    output logic [N_CHAN-1:0]   chan_open
);

    logic [1:0]            r_state;
    logic [IDX_W-1:0]      r_gnt;
    logic [IDX_W-1:0]      r_ptr;
    logic [N_CHAN-1:0]     r_done;

    logic [1:0]            w_state_nxt;
    logic [IDX_W-1:0]      w_gnt_nxt;
    logic [IDX_W-1:0]      w_ptr_nxt;
    logic [N_CHAN-1:0]     w_done_nxt;
    logic [N_CHAN-1:0]     w_chan_fin;
    logic [MAX_MASTER-1:0] w_req_pad;
    logic [MAX_IDX_W-1:0]  w_ptr_pad;
    logic [MAX_IDX_W-1:0]  w_pick;
    logic [IDX_W-1:0]      w_pick_gnt;

    always_comb begin
        w_req_pad               = '0;
        w_req_pad[N_MASTER-1:0] = req;
    end

    assign w_ptr_pad  = MAX_IDX_W'(r_ptr);
    assign w_pick     = rr_pick(w_req_pad, w_ptr_pad);
    assign w_pick_gnt = IDX_W'(w_pick);
    assign w_chan_fin = r_done | chan_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_done_nxt  = r_done;
        case (r_state)
            ARB_IDLE: begin
                if (|req) begin
                    w_state_nxt = ARB_REQ;
                    w_gnt_nxt   = w_pick_gnt;
                end
            end
            ARB_REQ: begin
                // Channels may complete in any order; leave once all have.
                if (&w_chan_fin) begin
                    w_state_nxt = ARB_RESP;
                    w_done_nxt  = '0;
                end else begin
                    w_done_nxt  = w_chan_fin;
                end
            end
            ARB_RESP: begin
                if (resp_hs) begin
                    w_state_nxt = ARB_IDLE;
                    w_ptr_nxt   = (r_gnt == IDX_W'(N_MASTER - 1)) ? '0 : r_gnt + 1'b1;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        state     = r_state;
        gnt       = r_gnt;
        chan_open = (r_state == ARB_REQ) ? ~r_done : '0;
    end

endmodule

`default_nettype wire

// File: rtl/nasti_lite_arbiter.sv
// ============================================================================
//  Module      : nasti_lite_arbiter
//  Description : Round-robin sharing of one NASTI-Lite slave port between
//                N_MASTER lite masters; independent write and read paths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nasti_lite_arbiter
    import nasti_lite_arb_pkg::*;
#(
    parameter int N_MASTER   = 2,
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [N_MASTER*ID_WIDTH-1:0]     s_aw_id,
    input  logic [N_MASTER*ADDR_WIDTH-1:0]   s_aw_addr,
    input  logic [N_MASTER*3-1:0]            s_aw_prot,
    input  logic [N_MASTER*USER_WIDTH-1:0]   s_aw_user,
    input  logic [N_MASTER-1:0]              s_aw_valid,
    output logic [N_MASTER-1:0]              s_aw_ready,

    input  logic [N_MASTER*DATA_WIDTH-1:0]   s_w_data,
    input  logic [N_MASTER*DATA_WIDTH/8-1:0] s_w_strb,
    input  logic [N_MASTER*USER_WIDTH-1:0]   s_w_user,
    input  logic [N_MASTER-1:0]              s_w_valid,
    output logic [N_MASTER-1:0]              s_w_ready,

    output logic [N_MASTER*ID_WIDTH-1:0]     s_b_id,
    output logic [N_MASTER*2-1:0]            s_b_resp,
    output logic [N_MASTER*USER_WIDTH-1:0]   s_b_user,
    output logic [N_MASTER-1:0]              s_b_valid,
    input  logic [N_MASTER-1:0]              s_b_ready,

    input  logic [N_MASTER*ID_WIDTH-1:0]     s_ar_id,
    input  logic [N_MASTER*ADDR_WIDTH-1:0]   s_ar_addr,
    input  logic [N_MASTER*3-1:0]            s_ar_prot,
    input  logic [N_MASTER*USER_WIDTH-1:0]   s_ar_user,
    input  logic [N_MASTER-1:0]              s_ar_valid,
    output logic [N_MASTER-1:0]              s_ar_ready,

    output logic [N_MASTER*ID_WIDTH-1:0]     s_r_id,
    output logic [N_MASTER*DATA_WIDTH-1:0]   s_r_data,
    output logic [N_MASTER*2-1:0]            s_r_resp,
    output logic [N_MASTER*USER_WIDTH-1:0]   s_r_user,
    output logic [N_MASTER-1:0]              s_r_valid,
    input  logic [N_MASTER-1:0]              s_r_ready,

    output logic [ID_WIDTH-1:0]              m_aw_id,
    output logic [ADDR_WIDTH-1:0]            m_aw_addr,
    output logic [2:0]                       m_aw_prot,
    output logic [USER_WIDTH-1:0]            m_aw_user,
    output logic                             m_aw_valid,
    input  logic                             m_aw_ready,

    output logic [DATA_WIDTH-1:0]            m_w_data,
    output logic [DATA_WIDTH/8-1:0]          m_w_strb,
    output logic [USER_WIDTH-1:0]            m_w_user,
    output logic                             m_w_valid,
    input  logic                             m_w_ready,

    input  logic [ID_WIDTH-1:0]              m_b_id,
    input  logic [1:0]                       m_b_resp,
    input  logic [USER_WIDTH-1:0]            m_b_user,
    input  logic                             m_b_valid,
    output logic                             m_b_ready,

    output logic [ID_WIDTH-1:0]              m_ar_id,
    output logic [ADDR_WIDTH-1:0]            m_ar_addr,
    output logic [2:0]                       m_ar_prot,
    output logic [USER_WIDTH-1:0]            m_ar_user,
    output logic                             m_ar_valid,
    input  logic                             m_ar_ready,

    input  logic [ID_WIDTH-1:0]              m_r_id,
    input  logic [DATA_WIDTH-1:0]            m_r_data,
    input  logic [1:0]                       m_r_resp,
    input  logic [USER_WIDTH-1:0]            m_r_user,
    input  logic                             m_r_valid,
    output logic                             m_r_ready
);

    localparam int IDX_W = $clog2(N_MASTER);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [1:0]       w_wr_state;
    logic [1:0]       w_rd_state;
    logic [IDX_W-1:0] w_wgnt;
    logic [IDX_W-1:0] w_rgnt;
    logic [1:0]       w_wr_open;
    logic [0:0]       w_rd_open;
    logic [1:0]       w_wr_hs;
    logic [0:0]       w_rd_hs;
    logic             w_b_hs;
    logic             w_r_hs;
    wstate_t          w_wstate;
    rstate_t          w_rstate;
    logic             w_wr_resp_ph;
    logic             w_rd_resp_ph;

    assign w_wstate     = wstate_t'(w_wr_state);
    assign w_rstate     = rstate_t'(w_rd_state);
    assign w_wr_resp_ph = (w_wstate == W_RESP);
    assign w_rd_resp_ph = (w_rstate == R_DATA);

    assign w_wr_hs = {m_w_valid & m_w_ready, m_aw_valid & m_aw_ready};
    assign w_rd_hs = m_ar_valid & m_ar_ready;
    assign w_b_hs  = m_b_valid & m_b_ready;
    assign w_r_hs  = m_r_valid & m_r_ready;

    // Write path: AW and W are the two request channels.
    nasti_lite_rr_arb #(
        .N_MASTER (N_MASTER),
        .N_CHAN   (2),
        .IDX_W    (IDX_W)
    ) u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (s_aw_valid),
        .chan_hs   (w_wr_hs),
        .resp_hs   (w_b_hs),
        .state     (w_wr_state),
        .gnt       (w_wgnt),
        .chan_open (w_wr_open)
    );

    nasti_lite_rr_arb #(
        .N_MASTER (N_MASTER),
        .N_CHAN   (1),
        .IDX_W    (IDX_W)
    ) u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (s_ar_valid),
        .chan_hs   (w_rd_hs),
        .resp_hs   (w_r_hs),
        .state     (w_rd_state),
        .gnt       (w_rgnt),
        .chan_open (w_rd_open)
    );

    always_comb begin
        m_aw_id    = '0;
        m_aw_addr  = '0;
        m_aw_prot  = '0;
        m_aw_user  = '0;
        m_aw_valid = 1'b0;
        m_w_data   = '0;
        m_w_strb   = '0;
        m_w_user   = '0;
        m_w_valid  = 1'b0;
        m_b_ready  = 1'b0;
        if (w_wstate == W_REQ) begin
            m_aw_id    = s_aw_id[int'(w_wgnt)*ID_WIDTH +: ID_WIDTH];
            m_aw_addr  = s_aw_addr[int'(w_wgnt)*ADDR_WIDTH +: ADDR_WIDTH];
            m_aw_prot  = s_aw_prot[int'(w_wgnt)*3 +: 3];
            m_aw_user  = s_aw_user[int'(w_wgnt)*USER_WIDTH +: USER_WIDTH];
            m_aw_valid = w_wr_open[0] & s_aw_valid[w_wgnt];
            m_w_data   = s_w_data[int'(w_wgnt)*DATA_WIDTH +: DATA_WIDTH];
            m_w_strb   = s_w_strb[int'(w_wgnt)*STRB_W +: STRB_W];
            m_w_user   = s_w_user[int'(w_wgnt)*USER_WIDTH +: USER_WIDTH];
            m_w_valid  = w_wr_open[1] & s_w_valid[w_wgnt];
        end
        if (w_wr_resp_ph) begin
            m_b_ready  = s_b_ready[w_wgnt];
        end
    end

    always_comb begin
        m_ar_id    = '0;
        m_ar_addr  = '0;
        m_ar_prot  = '0;
        m_ar_user  = '0;
        m_ar_valid = 1'b0;
        m_r_ready  = 1'b0;
        if (w_rstate == R_ADDR) begin
            m_ar_id    = s_ar_id[int'(w_rgnt)*ID_WIDTH +: ID_WIDTH];
            m_ar_addr  = s_ar_addr[int'(w_rgnt)*ADDR_WIDTH +: ADDR_WIDTH];
            m_ar_prot  = s_ar_prot[int'(w_rgnt)*3 +: 3];
            m_ar_user  = s_ar_user[int'(w_rgnt)*USER_WIDTH +: USER_WIDTH];
            m_ar_valid = w_rd_open[0] & s_ar_valid[w_rgnt];
        end
        if (w_rd_resp_ph) begin
            m_r_ready  = s_r_ready[w_rgnt];
        end
    end

    // Response and ready demux: only the granted slice sees anything.
    for (genvar i = 0; i < N_MASTER; i++) begin : g_master
        logic w_wr_sel;
        logic w_rd_sel;
        logic w_b_sel;
        logic w_r_sel;

        assign w_wr_sel = (w_wgnt == IDX_W'(i));
        assign w_rd_sel = (w_rgnt == IDX_W'(i));
        assign w_b_sel  = w_wr_sel & w_wr_resp_ph;
        assign w_r_sel  = w_rd_sel & w_rd_resp_ph;

        assign s_aw_ready[i] = w_wr_sel & w_wr_open[0] & m_aw_ready;
        assign s_w_ready[i]  = w_wr_sel & w_wr_open[1] & m_w_ready;
        assign s_ar_ready[i] = w_rd_sel & w_rd_open[0] & m_ar_ready;

        assign s_b_valid[i]                              = w_b_sel & m_b_valid;
        assign s_b_id[i*ID_WIDTH +: ID_WIDTH]            = w_b_sel ? m_b_id   : '0;
        assign s_b_resp[i*2 +: 2]                        = w_b_sel ? m_b_resp : '0;
        assign s_b_user[i*USER_WIDTH +: USER_WIDTH]      = w_b_sel ? m_b_user : '0;

        assign s_r_valid[i]                              = w_r_sel & m_r_valid;
        assign s_r_id[i*ID_WIDTH +: ID_WIDTH]            = w_r_sel ? m_r_id   : '0;
        assign s_r_data[i*DATA_WIDTH +: DATA_WIDTH]      = w_r_sel ? m_r_data : '0;
        assign s_r_resp[i*2 +: 2]                        = w_r_sel ? m_r_resp : '0;
        assign s_r_user[i*USER_WIDTH +: USER_WIDTH]      = w_r_sel ? m_r_user : '0;
    end

endmodule

`default_nettype wire
